change_dispenser: RTL and testbench

Output side of the vending machine. It accepts a collected credit total from the coin-collection stage and issues a one-cycle product-vend pulse. It then pays out change as a sequence of coins to a coin hopper over a valid/ack handshake. Coins use the same 2-bit code as the coin-collection input (00=25p, 01=50p, 10=1 rupee, 11=none); amounts are in paise.

---
 rtl/change_dispenser.sv | 164 ++++++++++++++++
 tb/tb_change_dispenser.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: output stage of the vending machine.
// Takes a collected credit, pulses vend when the credit covers the price,
// then pays the remaining change one coin at a time to a hopper over a
// valid/ack handshake, using greedy coin selection.
//
// Ports:
//   clock_i         clock, all state updates on the rising edge
//   reset_i         synchronous active-high reset
//   credit_valid_i  credit presented (taken only while ready_o=1)
//   credit_i        credit amount in paise
//   coin_ack_i      hopper took the coin on coin_out_o (honoured only in PAY)
//   ready_o         idle, a credit can be accepted
//   vend_o          one-cycle product-release pulse
//   coin_valid_o    coin_out_o holds a coin to dispense
//   coin_out_o      coin code 00=25p 01=50p 10=1 rupee, 11 when no coin
//   change_left_o   change still owed, in paise
//   done_o          one-cycle pulse at transaction completion
//   err_o           one-cycle pulse when a credit is rejected
//   fault_o         hopper ack timeout, sticky until reset
//
// state | meaning
// IDLE  | waiting for a credit, ready_o=1
// ERR   | rejected credit, err_o pulse
// VEND  | vend_o pulse, remainder already latched
// SEL   | choose next coin, or finish when nothing is owed
// PAY   | coin presented, waiting for coin_ack_i
// DONE  | done_o pulse
// FAULT | hopper never acknowledged; held until reset
module change_dispenser #(
  parameter int unsigned PRICE       = 100,
  parameter int unsigned MAX_CREDIT  = 175,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       credit_valid_i,
  input  logic [7:0] credit_i,
  input  logic       coin_ack_i,
  output logic       ready_o,
  output logic       vend_o,
  output logic       coin_valid_o,
  output logic [1:0] coin_out_o,
  output logic [7:0] change_left_o,
  output logic       done_o,
  output logic       err_o,
  output logic       fault_o
);

  localparam logic [7:0] PRICE_C = 8'(PRICE);
  localparam logic [7:0] MAX_C   = 8'(MAX_CREDIT);
  localparam int         TW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_C = TW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_VEND, S_SEL, S_PAY, S_DONE, S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [1:0]    coin_q, coin_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       ready_q, vend_q, coin_valid_q, done_q, err_q, fault_q;
  logic [1:0] coin_out_q;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      2'b00:   coin_value = 8'd25;
      2'b01:   coin_value = 8'd50;
      2'b10:   coin_value = 8'd100;
      default: coin_value = 8'd0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (credit_valid_i) begin
          // Rejected credits leave the remainder untouched.
          if ((credit_i % 8'd25) != 8'd0 || credit_i > MAX_C) begin
            state_d = S_ERR;
          end else if (credit_i >= PRICE_C) begin
            rem_d   = credit_i - PRICE_C;
            state_d = S_VEND;
          end else begin
            rem_d   = credit_i;
            state_d = S_SEL;
          end
        end
      end
      S_ERR:  state_d = S_IDLE;
      S_VEND: state_d = S_SEL;
      S_SEL: begin
        tmo_d = '0;
        if (rem_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          if (rem_q >= 8'd100)     coin_d = 2'b10;
          else if (rem_q >= 8'd50) coin_d = 2'b01;
          else                     coin_d = 2'b00;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        if (coin_ack_i) begin
          // Greedy choice guarantees the coin never exceeds the remainder.
          rem_d   = rem_q - coin_value(coin_q);
          tmo_d   = '0;
          state_d = S_SEL;
        end else if (tmo_q == TMO_C) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      rem_q        <= 8'd0;
      coin_q       <= 2'b11;
      tmo_q        <= '0;
      ready_q      <= 1'b1;
      vend_q       <= 1'b0;
      coin_valid_q <= 1'b0;
      coin_out_q   <= 2'b11;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      coin_q       <= coin_d;
      tmo_q        <= tmo_d;
      ready_q      <= (state_d == S_IDLE);
      vend_q       <= (state_d == S_VEND);
      coin_valid_q <= (state_d == S_PAY);
      coin_out_q   <= (state_d == S_PAY) ? coin_d : 2'b11;
      done_q       <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERR);
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign ready_o       = ready_q;
  assign vend_o        = vend_q;
  assign coin_valid_o  = coin_valid_q;
  assign coin_out_o    = coin_out_q;
  assign change_left_o = rem_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of credits with expected vend/err and
// coin/remainder sequences, plus hand sequences for timing, hopper stall
// and reset in the middle of a payout.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       credit_valid = 1'b0;
  logic [7:0] credit = 8'd0;
  logic       coin_ack = 1'b0;
  logic       ready, vend, coin_valid, done, err, fault;
  logic [1:0] coin_out;
  logic [7:0] change_left;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] credit;
    bit         vend;
    bit         err;
    int         ncoins;
    logic [1:0] c0;
    logic [7:0] r0;
    logic [1:0] c1;
    logic [7:0] r1;
  } vec_t;

  typedef struct packed {
    logic [1:0] coin;
    logic [7:0] rem;
  } exp_t;

  vec_t vecs[11];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  change_dispenser #(.PRICE(100), .MAX_CREDIT(175), .ACK_TIMEOUT(15)) dut (
    .clock_i(clk), .reset_i(rst), .credit_valid_i(credit_valid),
    .credit_i(credit), .coin_ack_i(coin_ack), .ready_o(ready), .vend_o(vend),
    .coin_valid_o(coin_valid), .coin_out_o(coin_out),
    .change_left_o(change_left), .done_o(done), .err_o(err), .fault_o(fault)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_vend"}, vend, 0);
    check({tag, "_coin_valid"}, coin_valid, 0);
    check({tag, "_coin_out"}, coin_out, 3);
    check({tag, "_change_left"}, change_left, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_fault"}, fault, 0);
  endtask

  // Presents one credit for a single cycle; the acceptance edge follows.
  task automatic offer(input logic [7:0] c, input logic ack);
    @(posedge clk); #1;
    credit = c; credit_valid = 1'b1; coin_ack = ack;
    @(posedge clk); #1;
    credit_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   vends = 0, errs = 0, dones = 0, coins = 0;
    bit   finished = 0, chk_rem = 0;
    logic [7:0] exp_rem = 8'd0;
    exp_t e;
    check({tag, "_ready_before"}, ready, 1);
    exp_q.delete();
    if (v.ncoins > 0) exp_q.push_back('{coin: v.c0, rem: v.r0});
    if (v.ncoins > 1) exp_q.push_back('{coin: v.c1, rem: v.r1});
    offer(v.credit, 1'b1);
    for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
      @(negedge clk);
      if (chk_rem) begin
        check({tag, "_change_left"}, change_left, exp_rem);
        chk_rem = 0;
      end
      if (vend) vends++;
      if (err) errs++;
      if (done) dones++;
      if (coin_valid && coin_ack) begin
        coins++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_coin_out"}, coin_out, e.coin);
          exp_rem = e.rem;
          chk_rem = 1;
        end
      end
      if (done || err) finished = 1;
    end
    check({tag, "_finished"}, finished, 1);
    check({tag, "_vend_count"}, vends, v.vend);
    check({tag, "_err_count"}, errs, v.err);
    check({tag, "_done_count"}, dones, v.err ? 0 : 1);
    check({tag, "_coin_count"}, coins, v.ncoins);
    @(negedge clk);
    check({tag, "_ready_after"}, ready, 1);
  endtask

  initial begin
    int   bad;
    bit   seen;
    vecs[0]  = '{8'd100, 1, 0, 0, 2'b11, 8'd0,  2'b11, 8'd0};
    vecs[1]  = '{8'd175, 1, 0, 2, 2'b01, 8'd25, 2'b00, 8'd0};
    vecs[2]  = '{8'd50,  0, 0, 1, 2'b01, 8'd0,  2'b11, 8'd0};
    vecs[3]  = '{8'd0,   0, 0, 0, 2'b11, 8'd0,  2'b11, 8'd0};
    vecs[4]  = '{8'd110, 0, 1, 0, 2'b11, 8'd0,  2'b11, 8'd0};
    vecs[5]  = '{8'd200, 0, 1, 0, 2'b11, 8'd0,  2'b11, 8'd0};
    vecs[6]  = '{8'd150, 1, 0, 1, 2'b01, 8'd0,  2'b11, 8'd0};
    vecs[7]  = '{8'd125, 1, 0, 1, 2'b00, 8'd0,  2'b11, 8'd0};
    vecs[8]  = '{8'd75,  0, 0, 2, 2'b01, 8'd25, 2'b00, 8'd0};
    vecs[9]  = '{8'd25,  0, 0, 1, 2'b00, 8'd0,  2'b11, 8'd0};
    vecs[10] = '{8'd180, 0, 1, 0, 2'b11, 8'd0,  2'b11, 8'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset0");
    rst = 1'b0;

    // Exact cycle timing for an exact-price credit.
    offer(8'd100, 1'b1);
    @(negedge clk);
    check("t1_vend_c1", vend, 1);
    check("t1_ready_c1", ready, 0);
    @(negedge clk);
    check("t1_vend_c2", vend, 0);
    check("t1_coin_valid_c2", coin_valid, 0);
    @(negedge clk);
    check("t1_done_c3", done, 1);
    @(negedge clk);
    check("t1_ready_c4", ready, 1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Hopper stall: coin held, fault after the ack timeout.
    offer(8'd150, 1'b0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (coin_valid) seen = 1;
    end
    check("stall_coin_valid_rise", seen, 1);
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (!coin_valid || coin_out != 2'b01 || fault) bad++;
    end
    check("stall_coin_held", bad, 0);
    @(negedge clk);
    check("stall_fault", fault, 1);
    check("stall_change_left", change_left, 50);
    check("stall_coin_valid", coin_valid, 0);
    check("stall_coin_out", coin_out, 3);
    check("stall_ready", ready, 0);
    repeat (5) @(negedge clk);
    check("stall_fault_sticky", fault, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("stall_reset");
    rst = 1'b0;

    // Reset during the first coin of a 175 credit.
    offer(8'd175, 1'b0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (coin_valid) seen = 1;
    end
    check("midpay_coin_valid_rise", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midpay_reset");
    rst = 1'b0;
    run_vec(vecs[0], "after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
